// File: rtl/con_unit.sv
// Registered branch-condition unit: evaluates a 3-bit condition either on the bus
// value (zero test) or on a signed compare of a captured operand A against the bus.
module con_unit #(
    parameter int         DATA_WIDTH  = 32,
    parameter logic       CON_INITIAL = 1'b0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] busIn,
    input  logic [2:0]            cond,
    input  logic                  conIn,
    input  logic                  relMode,
    input  logic                  loadA,
    output logic                  conOut,
    output logic                  conValid,
    output logic                  conErr,
    output logic                  aValid
);

    typedef enum logic {
        IDLE   = 1'b0,
        A_HELD = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic        [DATA_WIDTH-1:0]   a_q, a_d;
    logic                           con_out_q, con_out_d;
    logic                           con_valid_q, con_valid_d;
    logic                           con_err_q, con_err_d;

    logic signed [DATA_WIDTH:0]     rel_diff;
    logic                           rel_zero, rel_neg;
    logic                           zero_zero, zero_neg;

    function automatic logic eval_cond(input logic [2:0] c, input logic is_zero,
                                       input logic is_neg);
        logic r;
        case (c)
            3'b000:  r = is_zero;
            3'b001:  r = !is_zero;
            3'b010:  r = !is_neg;
            3'b011:  r = is_neg;
            3'b100:  r = !is_neg && !is_zero;
            3'b101:  r = is_neg || is_zero;
            3'b110:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // One extra bit of headroom makes the subtraction overflow-free, so the
    // top bit is always the true sign and a zero difference means A == busIn.
    always_comb begin
        rel_diff  = $signed({a_q[DATA_WIDTH-1], a_q}) - $signed({busIn[DATA_WIDTH-1], busIn});
        rel_neg   = rel_diff[DATA_WIDTH];
        rel_zero  = (rel_diff == '0);
        zero_neg  = busIn[DATA_WIDTH-1];
        zero_zero = (busIn == '0);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        con_out_d   = con_out_q;
        con_valid_d = 1'b0;
        con_err_d   = 1'b0;

        if (conIn) begin
            if (!relMode) begin
                con_out_d   = eval_cond(cond, zero_zero, zero_neg);
                con_valid_d = 1'b1;
            end else if (state_q == A_HELD) begin
                con_out_d   = eval_cond(cond, rel_zero, rel_neg);
                con_valid_d = 1'b1;
                state_d     = IDLE;
            end else begin
                con_err_d   = 1'b1;
            end
        end

        // A capture takes priority over consumption; the evaluation above used old A.
        if (loadA) begin
            a_d     = busIn;
            state_d = A_HELD;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q     <= IDLE;
            a_q         <= '0;
            con_out_q   <= CON_INITIAL;
            con_valid_q <= 1'b0;
            con_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            con_out_q   <= con_out_d;
            con_valid_q <= con_valid_d;
            con_err_q   <= con_err_d;
        end
    end

    assign conOut   = con_out_q;
    assign conValid = con_valid_q;
    assign conErr   = con_err_q;
    assign aValid   = (state_q == A_HELD);

endmodule

// File: tb/tb_con_unit.sv
// Directed, table-driven bench for con_unit with hand-computed expectations.
module tb_con_unit;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          clear;
    logic [DW-1:0] busIn;
    logic [2:0]    cond;
    logic          conIn, relMode, loadA;
    logic          conOut, conValid, conErr, aValid;

    int n_checks = 0;
    int n_fail   = 0;

    con_unit #(.DATA_WIDTH(DW), .CON_INITIAL(1'b0)) dut (
        .clock    (clock),
        .clear    (clear),
        .busIn    (busIn),
        .cond     (cond),
        .conIn    (conIn),
        .relMode  (relMode),
        .loadA    (loadA),
        .conOut   (conOut),
        .conValid (conValid),
        .conErr   (conErr),
        .aValid   (aValid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] bus;
        logic [7:0]    mask;   // bit i = expected conOut for cond code i
    } zvec_t;

    typedef struct {
        logic [DW-1:0] bus;
        logic [2:0]    cd;
        logic          exp;
    } vec_t;

    zvec_t ztab[5];
    vec_t  vtab[40];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic clr, input logic ci, input logic rm, input logic la,
                         input logic [2:0] cd, input logic [DW-1:0] b);
        clear = clr; conIn = ci; relMode = rm; loadA = la; cond = cd; busIn = b;
        tick();
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, '0);
    endtask

    task automatic chk_out(input string name, input logic o, input logic v,
                           input logic e, input logic a);
        chk({name, ".conOut"},   {31'b0, conOut},   {31'b0, o});
        chk({name, ".conValid"}, {31'b0, conValid}, {31'b0, v});
        chk({name, ".conErr"},   {31'b0, conErr},   {31'b0, e});
        chk({name, ".aValid"},   {31'b0, aValid},   {31'b0, a});
    endtask

    initial begin
        ztab[0] = '{32'h0000_0000, 8'h65};
        ztab[1] = '{32'h0000_0001, 8'h56};
        ztab[2] = '{32'hFFFF_FFFF, 8'h6A};
        ztab[3] = '{32'h8000_0000, 8'h6A};
        ztab[4] = '{32'h7FFF_FFFF, 8'h56};
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 8; c++) begin
                vtab[i*8+c].bus = ztab[i].bus;
                vtab[i*8+c].cd  = c[2:0];
                vtab[i*8+c].exp = ztab[i].mask[c];
            end
        end

        clear = 1'b0; conIn = 1'b0; relMode = 1'b0; loadA = 1'b0; cond = '0; busIn = '0;

        // Reset held with strobes active
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 32'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 32'd5);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        chk_out("post_reset_quiet", 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero-mode sweep
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, vtab[k].cd, vtab[k].bus);
            chk_out($sformatf("zero[%0h,c%0d]", vtab[k].bus, vtab[k].cd),
                    vtab[k].exp, 1'b1, 1'b0, 1'b0);
        end
        idle();
        chk_out("zero_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // Relative: 5 < 7
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd5);
        chk_out("rel1_load", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 32'd7);
        chk_out("rel1_lt", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'd0);
        chk_out("rel_clear_out", 1'b0, 1'b1, 1'b0, 1'b0);

        // Relative: most-negative < 1
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h8000_0000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 32'd1);
        chk_out("rel2_lt", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'd0);

        // Relative: most-positive > -1
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h7FFF_FFFF);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF);
        chk_out("rel3_gt", 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk_out("rel3_hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // Error path: relative compare with nothing held (never would clear conOut)
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 32'd0);
        chk_out("err_pulse", 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        chk_out("err_once", 1'b1, 1'b0, 1'b0, 1'b0);

        // Simultaneous conIn + loadA with A held
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 32'd3);
        chk_out("sim_eq", 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'd3);
        chk_out("sim_ne", 1'b0, 1'b1, 1'b0, 1'b0);

        // Old A used for evaluation, new A captured
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 32'd8);
        chk_out("sim_oldA", 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'd8);
        chk_out("sim_newA", 1'b1, 1'b1, 1'b0, 1'b0);

        // Simultaneous in IDLE: error, A still captured
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 32'd4);
        chk_out("sim_idle_err", 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 32'd6);
        chk_out("sim_idle_lt", 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back zero-mode evaluations
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'd0);
        chk_out("b2b_0", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'd0);
        chk_out("b2b_1", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5);
        chk_out("b2b_2", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'd5);
        chk_out("b2b_3", 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset during a relative evaluation
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd9);
        chk_out("mid_load", 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 32'd2);
        chk_out("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 32'd2);
        chk_out("mid_noA", 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/con_unit.md
# con_unit

Parametrised, registered branch-condition unit for the datapath's conditional-branch path. Evaluates a 3-bit condition code either against zero (value on the bus) or as a signed relative compare between a previously captured operand A and the bus value. The result is held in a flip-flop that the control unit reads to decide whether to load PC. It generalises the single-cycle zero-test CON flip-flop with a wider condition set, a two-operand mode and a valid/error handshake.

## Interface

- DATA_WIDTH, 32: bus and operand width; must be ≥ 2.
- CON_INITIAL, 0: value of conOut after reset.

- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset: synchronous, active-low; sampled on the rising edge of clock.
- busIn  in  DATA_WIDTH  operand B / zero-test value, two's complement.
- cond  in  3  condition code from IR, sampled with conIn.
- conIn  in  1  evaluate strobe.
- relMode  in  1  0 = test busIn against zero; 1 = compare A against busIn. Sampled with conIn.
- loadA  in  1  capture busIn into operand register A.
- conOut  out  1  registered branch decision.
- conValid  out  1  one-cycle pulse: conOut was updated this cycle.
- conErr  out  1  one-cycle pulse: relative compare requested with no A held.
- aValid  out  1  high while operand A is held (state A_HELD).

## Operation

- Condition codes, with X = busIn (zero mode) or X = A − busIn (relative mode):
  - 000 eq: X == 0.
  - 001 ne: X != 0.
  - 010 ge: X ≥ 0 (signed).
  - 011 lt: X < 0 (signed).
  - 100 gt: X > 0.
  - 101 le: X ≤ 0.
  - 110 always: 1.
  - 111 never: 0.
- Relative arithmetic:
  - Sign-extend A and busIn to DATA_WIDTH+1 bits and subtract. The sign bit of the (DATA_WIDTH+1)-bit difference gives "less than".
  - Equality is A == busIn.
  - No overflow is possible. For example, A = most-negative and busIn = 1 is lt.
- States: IDLE and A_HELD.
  - loadA in either state: A ← busIn, next state A_HELD.
  - conIn with relMode=0: evaluate; state and A unchanged.
  - conIn with relMode=1 in A_HELD: evaluate with the current A, then consume it (next state IDLE), unless loadA is also asserted.
  - conIn with relMode=1 in IDLE: no evaluation. conOut holds, conValid=0, conErr pulses.
- Simultaneous conIn and loadA: the evaluation uses the old A. The new A is then captured and the next state is A_HELD. If no A was held, the rule above applies: conErr pulses and the new A is captured.
- conOut holds its value between evaluations.

## Timing

- Reset (clear=0 at an edge) overrides all other inputs. It sets:
  - conOut=CON_INITIAL, conValid=0, conErr=0.
  - aValid=0, A=0, state IDLE.
- Latency: inputs are sampled at edge N. conOut, conValid and conErr change at edge N and are visible during cycle N+1.
- Evaluations may be issued back-to-back every cycle. Each produces its own conValid pulse.
- aValid changes at the same edge as the state change.
- Clear asserted in the same cycle as conIn or loadA: reset wins. No pulse is produced and A is not captured.
- Purely synchronous logic. No combinational path from inputs to outputs.

## Test plan

- Reset: hold clear=0 for 2 cycles with conIn=1, loadA=1 → conOut=CON_INITIAL, conValid=0, aValid=0. Release and check nothing changes without strobes.
- Zero mode sweep (DATA_WIDTH=32): busIn ∈ {0, 1, 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF} × all 8 cond codes → conOut matches the table one cycle later, with a conValid pulse on every evaluation.
- Relative mode:
  - loadA with 5, then conIn with relMode=1, cond=011, busIn=7 → conOut=1, aValid falls.
  - Repeat with A=0x80000000, busIn=1, cond=011 → conOut=1.
  - Repeat with A=0x7FFFFFFF, busIn=0xFFFFFFFF, cond=100 → conOut=1.
- Error path: from IDLE, conIn with relMode=1 → conErr pulses once, conValid=0, conOut unchanged.
- Simultaneous events:
  - With A=3 held, assert conIn (relMode=1, cond=000, busIn=3) and loadA together → conOut=1 and A=3 (the new busIn). aValid stays 1.
  - Next cycle, evaluate cond=001 with busIn=3 → conOut=0.
- Back-to-back and reset mid-stream: issue 4 consecutive evaluations (zero mode) → 4 conValid pulses. Then pull clear low during a relMode evaluation → no pulse, aValid=0, conOut=CON_INITIAL.
